// File: rtl/uacc_vec.sv
// Multi-lane windowed unary temporal accumulator: each lane integrates a signed
// unary product stream over win_len enabled cycles, then merges with the column sum.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; sum_o holds the last merged result
// RUN   | integrating prod_bit into partials on each en=1 cycle
// MERGE | one cycle: sum_o <= op(partial + sum_i), done follows
module uacc_vec #(
  parameter int LANES = 4,
  parameter int WIDTH = 16,
  parameter int CNT_W = 8,
  parameter int SAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   start,
  input  logic [CNT_W-1:0]       win_len,
  input  logic                   en,
  input  logic [LANES-1:0]       sign_i,
  input  logic [LANES-1:0]       sign_w,
  input  logic [LANES-1:0]       prod_bit,
  input  logic [LANES*WIDTH-1:0] sum_i,
  output logic [LANES*WIDTH-1:0] sum_o,
  output logic                   busy,
  output logic                   done,
  output logic [LANES-1:0]       sat_flag
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_MERGE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_part [LANES];
  logic [LANES*WIDTH-1:0] r_sum;
  logic                   r_done;
  logic [LANES-1:0]       r_sat;

  logic                   w_accept;
  logic                   w_step_en;
  logic                   w_merge_en;
  logic [WIDTH-1:0]       w_part_nxt [LANES];
  logic [LANES-1:0]       w_part_ovf;
  logic [LANES*WIDTH-1:0] w_merge_nxt;
  logic [LANES-1:0]       w_merge_ovf;

  function automatic logic ovf(input logic [WIDTH:0] s);
    return s[WIDTH] ^ s[WIDTH-1];
  endfunction

  // Overflow at WIDTH+1 bits: clamp toward the sign of the true result, or wrap.
  function automatic logic [WIDTH-1:0] fit(input logic [WIDTH:0] s);
    if (SAT != 0 && ovf(s))
      return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      return s[WIDTH-1:0];
  endfunction

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH:0] w_step;
    logic [WIDTH:0] w_psum;
    logic [WIDTH:0] w_msum;
    logic [WIDTH-1:0] w_sum_in;

    assign w_sum_in = sum_i[k*WIDTH +: WIDTH];
    assign w_step   = !prod_bit[k]              ? {(WIDTH+1){1'b0}} :
                      (sign_i[k] ^ sign_w[k])   ? {(WIDTH+1){1'b1}} :
                                                  (WIDTH+1)'(1);
    assign w_psum   = {r_part[k][WIDTH-1], r_part[k]} + w_step;
    assign w_msum   = {r_part[k][WIDTH-1], r_part[k]} + {w_sum_in[WIDTH-1], w_sum_in};

    assign w_part_nxt[k]                 = fit(w_psum);
    assign w_part_ovf[k]                 = (SAT != 0) && ovf(w_psum);
    assign w_merge_nxt[k*WIDTH +: WIDTH] = fit(w_msum);
    assign w_merge_ovf[k]                = (SAT != 0) && ovf(w_msum);
  end

  assign w_accept   = (r_state == S_IDLE) && start && !clr;
  assign w_step_en  = (r_state == S_RUN) && en;
  assign w_merge_en = (r_state == S_MERGE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (win_len != '0) ? S_RUN : S_MERGE;
      S_RUN:   if (en && r_cnt == CNT_W'(1)) w_state_nxt = S_MERGE;
      S_MERGE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (clr) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sum  <= '0;
      r_done <= 1'b0;
      r_sat  <= '0;
      for (int k = 0; k < LANES; k++) r_part[k] <= '0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_sum  <= '0;
      r_done <= 1'b0;
      r_sat  <= '0;
      for (int k = 0; k < LANES; k++) r_part[k] <= '0;
    end else begin
      r_done <= w_merge_en;
      if (w_accept) begin
        r_cnt <= win_len;
        r_sat <= '0;
        for (int k = 0; k < LANES; k++) r_part[k] <= '0;
      end else if (w_step_en) begin
        r_cnt <= r_cnt - CNT_W'(1);
        r_sat <= r_sat | w_part_ovf;
        for (int k = 0; k < LANES; k++) r_part[k] <= w_part_nxt[k];
      end else if (w_merge_en) begin
        r_sum <= w_merge_nxt;
        r_sat <= r_sat | w_merge_ovf;
      end
    end
  end

  assign sum_o    = r_sum;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign sat_flag = r_sat;

endmodule
